xccela_ctrl_tx_seq: RTL and testbench
=====================================

XCCELA_CTRL_TX_SEQ -- requirements
Module: xccela_ctrl_tx_seq

Interface
REQ-001 SHALL have parameter RD_CMD, default 8'h20, linear-burst read opcode.
REQ-002 SHALL have parameter WR_CMD, default 8'hA0, linear-burst write opcode.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-006 SHALL have port cmd_rw  in  1  1 = read, 0 = write.
REQ-007 SHALL have port cmd_addr  in  32  word address.
REQ-008 SHALL have port cmd_len  in  8  burst length in 16-bit words minus one.
REQ-009 SHALL have port lat_cycles  in  4  latency clocks between CA and data.
REQ-010 SHALL have ports wdata_valid/wdata_ready  in/out  1/1  write-data handshake.
REQ-011 SHALL have port wdata  in  16  write word; [15:8] rise byte, [7:0] fall byte.
REQ-012 SHALL have ports dq_rise/dq_fall  out  8/8  bytes for the downstream DDR output mux (I0/I1 per bit).
REQ-013 SHALL have port dq_oe  out  1  DQ output enable.
REQ-014 SHALL have port ce_n  out  1  device chip enable, active low.
REQ-015 SHALL have port ck_en  out  1  enables device clock toggling this cycle.
REQ-016 SHALL have ports rd_start/rd_done  out/in  1/1  read-capture start pulse / completion pulse from receive path.
REQ-017 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, CA, LAT, WDATA, RDATA, END.
REQ-019 cmd_ready SHALL be high only in IDLE; handshake (cmd_valid & cmd_ready) registers cmd fields and enters CA next cycle.
REQ-020 CA SHALL last exactly 3 cycles presenting the 48-bit word {opcode, cmd_addr, 8'h00} MSB-first, 16 bits per cycle (upper byte on dq_rise); dq_oe=1, ck_en=1, ce_n=0.
REQ-021 After CA: lat_cycles=0 SHALL go directly to WDATA/RDATA; else LAT for exactly lat_cycles cycles with dq_oe=0, ck_en=1, ce_n=0.
REQ-022 WDATA: wdata_ready=1; each accepted word SHALL appear on dq_rise/dq_fall the same cycle with dq_oe=1, ck_en=1; after cmd_len+1 words go to END.
REQ-023 WDATA with wdata_valid=0 SHALL stall: ck_en=0, dq outputs hold last value, word count unchanged, ce_n stays low.
REQ-024 RDATA entry SHALL pulse rd_start for exactly one cycle; state holds with dq_oe=0, ck_en=1 until rd_done, then END; rd_done outside RDATA SHALL be ignored.
REQ-025 END SHALL last exactly 1 cycle with ce_n=1, ck_en=0, dq_oe=0, then IDLE; back-to-back commands thus have minimum 1 cycle ce_n high.
REQ-026 cmd_len=255 SHALL transfer 256 words; counter SHALL NOT wrap early.
REQ-027 All outputs SHALL be registered; dq_rise/dq_fall SHALL be 8'h00 whenever dq_oe=0.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, ce_n=1, dq_oe=0, ck_en=0, cmd_ready=0, wdata_ready=0, rd_start=0, busy=0, dq=0, regardless of operation in progress; cmd_ready rises the first cycle after release.
REQ-029 A command aborted by reset SHALL NOT resume; no partial state survives.

Structure
REQ-030 State encoding, CA width (48) and opcode defaults SHALL live in shared package xccela_ctrl_pkg.
REQ-031 One sub-module, xccela_ctrl_dn_cnt (8-bit loadable down-counter with zero flag), SHALL serve CA, LAT and word counting.

Verification
REQ-032 Write, addr 32'h0000_1234, len 1, lat 3, data 16'hA1B2,16'hC3D4 -> CA 16'hA000,16'h0012,16'h3400; 3 LAT cycles; dq A1/B2 then C3/D4; 1 END cycle.
REQ-033 Read, lat 0, addr 0 -> CA 16'h2000,0,0; rd_start pulse cycle 4; hold until rd_done; END; busy low after.
REQ-034 Write len 2 with wdata_valid low 2 cycles mid-burst -> ck_en=0 for exactly those 2 cycles, 3 words total, no duplication.
REQ-035 reset_n low during LAT -> ce_n=1, dq_oe=0 same cycle; after release cmd_ready=1, new command completes normally.
REQ-036 Write len 255 -> exactly 256 accepted words, then END; rd_done pulsed in IDLE -> no effect.

Source files
------------

// File: rtl/xccela_ctrl_pkg.sv
// Shared definitions for the Xccela controller transmit sequencer:
// FSM state encoding, command/address framing width, default opcodes and
// the pin bundle that drives the device-facing outputs.
package xccela_ctrl_pkg;

  localparam int unsigned CA_W   = 48;
  localparam int unsigned BEAT_W = 16;
  localparam int unsigned DQ_W   = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ST_W   = 3;

  localparam logic [7:0] RD_CMD_DEF = 8'h20;
  localparam logic [7:0] WR_CMD_DEF = 8'hA0;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_CA    = 3'd1;
  localparam logic [ST_W-1:0] ST_LAT   = 3'd2;
  localparam logic [ST_W-1:0] ST_WDATA = 3'd3;
  localparam logic [ST_W-1:0] ST_RDATA = 3'd4;
  localparam logic [ST_W-1:0] ST_END   = 3'd5;

  // CA phase is three beats; the counter is loaded with beats minus one.
  localparam logic [CNT_W-1:0] CA_LAST = 8'd2;

  // Device-facing pin bundle, registered as one unit.
  typedef struct packed {
    logic            ce_n;
    logic            oe;
    logic            ck_en;
    logic [DQ_W-1:0] rise;
    logic [DQ_W-1:0] fall;
  } pin_t;

  localparam pin_t PINS_OFF = '{ce_n: 1'b1, oe: 1'b0, ck_en: 1'b0, rise: '0, fall: '0};

  function automatic pin_t mk_pins(input logic ce_n, input logic oe, input logic ck_en,
                                   input logic [BEAT_W-1:0] w);
    pin_t p;
    p.ce_n  = ce_n;
    p.oe    = oe;
    p.ck_en = ck_en;
    p.rise  = w[BEAT_W-1:DQ_W];
    p.fall  = w[DQ_W-1:0];
    return p;
  endfunction

  function automatic logic [CA_W-1:0] ca_word(input logic [7:0] op, input logic [31:0] addr);
    return {op, addr, 8'h00};
  endfunction

endpackage

// File: rtl/xccela_ctrl_dn_cnt.sv
// Loadable 8-bit down-counter with a registered zero flag; shared by the
// CA beat, latency and write-word counting of the transmit sequencer.
//   load/load_val : synchronous load (has priority over dec)
//   dec           : decrement, saturating at zero
//   count / zero  : current value and (count == 0)
module xccela_ctrl_dn_cnt
  import xccela_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      zero  <= (load_val == '0);
    end else if (dec && !zero) begin
      count <= count - CNT_W'(1);
      zero  <= (count == CNT_W'(1));
    end
  end

endmodule

// File: rtl/xccela_ctrl_tx_seq.sv
// Xccela/HyperRAM-style transmit sequencer. Accepts one linear burst command,
// drives the 48-bit CA phase, the latency gap and the write-data or read
// window, then one END cycle with CE# high.
// Ports: cmd_* command handshake and fields, lat_cycles latency clocks,
//        wdata_* write-data handshake, dq_rise/dq_fall/dq_oe DDR data pins,
//        ce_n chip enable, ck_en device clock gate, rd_start/rd_done receive
//        path handshake, busy (not IDLE).
// Every output is registered and reflects the state of the same cycle, so a
// write word handshaked in cycle t is on the pins with ck_en in cycle t+1.
// wdata_ready is therefore raised one cycle ahead of the first data slot.
module xccela_ctrl_tx_seq
  import xccela_ctrl_pkg::*;
#(
  parameter logic [7:0] RD_CMD = RD_CMD_DEF,
  parameter logic [7:0] WR_CMD = WR_CMD_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [31:0]       cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [3:0]        lat_cycles,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [BEAT_W-1:0] wdata,
  output logic [DQ_W-1:0]   dq_rise,
  output logic [DQ_W-1:0]   dq_fall,
  output logic              dq_oe,
  output logic              ce_n,
  output logic              ck_en,
  output logic              rd_start,
  input  logic              rd_done,
  output logic              busy
);

  logic [ST_W-1:0]  state, state_n;
  pin_t             pins, pins_n;
  logic [CA_W-1:0]  ca_sr, ca_sr_n, ca_new;
  logic             rw_q;
  logic [7:0]       len_q;
  logic [3:0]       lat_q;
  logic             wdone, wdone_n;
  logic             cmd_fire, accept, data_go, ready_pre, rd_start_n, wdata_ready_n;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign accept   = wdata_valid & wdata_ready;
  assign ca_new   = ca_word(cmd_rw ? RD_CMD : WR_CMD, cmd_addr);

  xccela_ctrl_dn_cnt u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // Command fields captured at the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rw_q  <= 1'b0;
      len_q <= '0;
      lat_q <= '0;
    end else if (cmd_fire) begin
      rw_q  <= cmd_rw;
      len_q <= cmd_len;
      lat_q <= lat_cycles;
    end
  end

  // Next state and next pin values.
  always_comb begin
    state_n    = state;
    pins_n     = PINS_OFF;
    ca_sr_n    = ca_sr;
    wdone_n    = wdone;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = '0;
    rd_start_n = 1'b0;
    ready_pre  = 1'b0;
    data_go    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_n  = ST_CA;
          pins_n   = mk_pins(1'b0, 1'b1, 1'b1, ca_new[CA_W-1 -: BEAT_W]);
          ca_sr_n  = {ca_new[CA_W-BEAT_W-1:0], BEAT_W'(0)};
          cnt_load = 1'b1;
          cnt_val  = CA_LAST;
        end
      end
      ST_CA: begin
        if (!cnt_zero) begin
          cnt_dec   = 1'b1;
          pins_n    = mk_pins(1'b0, 1'b1, 1'b1, ca_sr[CA_W-1 -: BEAT_W]);
          ca_sr_n   = {ca_sr[CA_W-BEAT_W-1:0], BEAT_W'(0)};
          // Next beat is the last CA beat and data follows directly.
          ready_pre = (cnt == CNT_W'(1)) && (lat_q == 4'd0) && !rw_q;
        end else if (lat_q != 4'd0) begin
          state_n   = ST_LAT;
          pins_n    = mk_pins(1'b0, 1'b0, 1'b1, '0);
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(lat_q) - CNT_W'(1);
          ready_pre = (lat_q == 4'd1) && !rw_q;
        end else begin
          data_go = 1'b1;
        end
      end
      ST_LAT: begin
        if (!cnt_zero) begin
          cnt_dec   = 1'b1;
          pins_n    = mk_pins(1'b0, 1'b0, 1'b1, '0);
          ready_pre = (cnt == CNT_W'(1)) && !rw_q;
        end else begin
          data_go = 1'b1;
        end
      end
      ST_WDATA: begin
        if (wdone) begin
          state_n = ST_END;
        end else if (accept) begin
          pins_n = mk_pins(1'b0, 1'b1, 1'b1, wdata);
          if (cnt_zero) wdone_n = 1'b1;
          else          cnt_dec = 1'b1;
        end else begin
          pins_n = mk_pins(1'b0, 1'b1, 1'b0, {pins.rise, pins.fall});
        end
      end
      ST_RDATA: begin
        if (rd_done) state_n = ST_END;
        else         pins_n  = mk_pins(1'b0, 1'b0, 1'b1, '0);
      end
      ST_END:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Leaving CA/LAT into the data phase. For writes the counter holds the
    // words still to accept minus one; wdone marks that all were accepted,
    // which keeps a 256-word burst within 8 bits.
    if (data_go) begin
      if (rw_q) begin
        state_n    = ST_RDATA;
        pins_n     = mk_pins(1'b0, 1'b0, 1'b1, '0);
        rd_start_n = 1'b1;
      end else begin
        state_n = ST_WDATA;
        wdone_n = 1'b0;
        if (accept) begin
          pins_n = mk_pins(1'b0, 1'b1, 1'b1, wdata);
          if (len_q == 8'd0) begin
            wdone_n = 1'b1;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = len_q - 8'd1;
          end
        end else begin
          pins_n   = mk_pins(1'b0, 1'b1, 1'b0, {pins.rise, pins.fall});
          cnt_load = 1'b1;
          cnt_val  = len_q;
        end
      end
    end

    wdata_ready_n = ready_pre || ((state_n == ST_WDATA) && !wdone_n);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pins        <= PINS_OFF;
      ca_sr       <= '0;
      wdone       <= 1'b0;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rd_start    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      pins        <= pins_n;
      ca_sr       <= ca_sr_n;
      wdone       <= wdone_n;
      cmd_ready   <= (state_n == ST_IDLE);
      wdata_ready <= wdata_ready_n;
      rd_start    <= rd_start_n;
      busy        <= (state_n != ST_IDLE);
    end
  end

  assign ce_n    = pins.ce_n;
  assign dq_oe   = pins.oe;
  assign ck_en   = pins.ck_en;
  assign dq_rise = pins.rise;
  assign dq_fall = pins.fall;

endmodule

// File: tb/tb_xccela_ctrl_tx_seq.sv
// Directed self-checking bench for xccela_ctrl_tx_seq. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_xccela_ctrl_tx_seq;

  localparam logic [7:0] WR = 8'hA0;
  localparam logic [7:0] RD = 8'h20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  lat_cycles;
  logic        wdata_valid, wdata_ready;
  logic [15:0] wdata;
  logic [7:0]  dq_rise, dq_fall;
  logic        dq_oe, ce_n, ck_en, rd_start, rd_done, busy;
  logic [18:0] bus;

  int n_checks = 0;
  int n_pass   = 0;

  xccela_ctrl_tx_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .lat_cycles  (lat_cycles),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .dq_rise     (dq_rise),
    .dq_fall     (dq_fall),
    .dq_oe       (dq_oe),
    .ce_n        (ce_n),
    .ck_en       (ck_en),
    .rd_start    (rd_start),
    .rd_done     (rd_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  assign bus = {ce_n, dq_oe, ck_en, dq_rise, dq_fall};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  function automatic logic [18:0] pins(input logic ce, input logic oe, input logic ck,
                                       input logic [15:0] w);
    return {ce, oe, ck, w};
  endfunction

  // Distinct word per burst index; index 0/1 give A1B2/C3D4.
  function automatic logic [15:0] word(input int i);
    return 16'hA1B2 + 16'(i) * 16'h2222;
  endfunction

  // Write burst; stall_n cycles of wdata_valid low once stall_after words are in.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] lat,
                          input int stall_after, input int stall_n);
    logic [47:0] ca;
    logic [18:0] exp;
    logic [15:0] shown, drv_word;
    logic        exp_rdy, drove, done;
    int          total, acc, stalls, lows, k;
    ca    = {WR, addr, 8'h00};
    total = int'(len) + 1;
    acc = 0; stalls = 0; lows = 0; k = 0;
    drove = 1'b0; done = 1'b0; shown = '0; drv_word = '0;
    check("wr_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = addr; cmd_len = len; lat_cycles = lat;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!done && k < 1000) begin
      if (k < 3)                exp = pins(1'b0, 1'b1, 1'b1, ca[47-16*k -: 16]);
      else if (k < 3 + int'(lat)) exp = pins(1'b0, 1'b0, 1'b1, 16'h0000);
      else begin
        if (drove) exp = pins(1'b0, 1'b1, 1'b1, drv_word);
        else begin
          exp = pins(1'b0, 1'b1, 1'b0, shown);
          lows++;
        end
        if (drove && acc == total) done = 1'b1;
      end
      check("wr_pins", bus, exp);
      shown   = exp[15:0];
      exp_rdy = (k >= 2 + int'(lat)) && (acc < total);
      check("wr_ready", wdata_ready, exp_rdy);
      drove = 1'b0;
      if (exp_rdy && !(acc == stall_after && stalls < stall_n)) begin
        wdata_valid = 1'b1; wdata = word(acc); drv_word = word(acc);
        acc++; drove = 1'b1;
      end else begin
        wdata_valid = 1'b0;
        if (exp_rdy) stalls++;
      end
      @(negedge clk);
      k++;
    end
    wdata_valid = 1'b0;
    check("wr_done", done, 1'b1);
    check("wr_words", acc, total);
    check("wr_stall_cycles", lows, stall_n);
    check("wr_end_pins", bus, pins(1'b1, 1'b0, 1'b0, 16'h0000));
    check("wr_end_busy", busy, 1'b1);
    @(negedge clk);
    check("wr_idle_busy", busy, 1'b0);
    check("wr_idle_ready", cmd_ready, 1'b1);
  endtask

  // Read burst; rd_done returned hold cycles after rd_start.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] lat, input int hold);
    logic [47:0] ca;
    ca = {RD, addr, 8'h00};
    check("rd_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = addr; cmd_len = 8'h07; lat_cycles = lat;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rd_ca_pins", bus, pins(1'b0, 1'b1, 1'b1, ca[47-16*k -: 16]));
      check("rd_ca_start", rd_start, 1'b0);
      @(negedge clk);
    end
    for (int k = 0; k < int'(lat); k++) begin
      check("rd_lat_pins", bus, pins(1'b0, 1'b0, 1'b1, 16'h0000));
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      check("rd_data_pins", bus, pins(1'b0, 1'b0, 1'b1, 16'h0000));
      check("rd_start_pulse", rd_start, (h == 0));
      if (h == hold) rd_done = 1'b1;
      @(negedge clk);
    end
    rd_done = 1'b0;
    check("rd_end_pins", bus, pins(1'b1, 1'b0, 1'b0, 16'h0000));
    check("rd_end_busy", busy, 1'b1);
    @(negedge clk);
    check("rd_idle_busy", busy, 1'b0);
    check("rd_idle_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0;
    lat_cycles = '0; wdata_valid = 1'b0; wdata = '0; rd_done = 1'b0;
    @(negedge clk);
    check("rst_pins", bus, pins(1'b1, 1'b0, 1'b0, 16'h0000));
    check("rst_flags", {cmd_ready, wdata_ready, rd_start, busy}, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", cmd_ready, 1'b1);

    // Nominal write, len 1, lat 3: A000/0012/3400, 3 LAT, A1B2 then C3D4.
    do_write(32'h0000_1234, 8'd1, 4'd3, 99, 0);
    // Read, lat 0, addr 0: rd_start in the cycle after the third CA beat.
    do_read(32'h0000_0000, 4'd0, 3);
    // Write len 2 with two stall cycles after the first word.
    do_write(32'hDEAD_BEEF, 8'd2, 4'd1, 1, 2);
    // Single word, stall in the very first data slot.
    do_write(32'h0000_00FF, 8'd0, 4'd2, 0, 1);
    // Read with latency and immediate rd_done.
    do_read(32'h8765_4321, 4'd2, 0);

    // rd_done while idle is ignored.
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    check("idle_rd_done_busy", busy, 1'b0);
    check("idle_rd_done_pins", {ce_n, rd_start, cmd_ready}, 3'b101);

    // Reset during LAT aborts immediately and does not resume.
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h0000_55AA; cmd_len = 8'd0; lat_cycles = 4'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("lat_before_rst", bus, pins(1'b0, 1'b0, 1'b1, 16'h0000));
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_pins", bus, pins(1'b1, 1'b0, 1'b0, 16'h0000));
    check("rst_async_flags", {cmd_ready, wdata_ready, rd_start, busy}, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", {ce_n, busy, cmd_ready, wdata_ready}, 4'b1010);
    end
    do_write(32'h0102_0304, 8'd3, 4'd2, 99, 0);

    // Longest burst: 256 words with no latency.
    do_write(32'hFFFF_FFFE, 8'd255, 4'd0, 300, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
